// File: rtl/vga_pll_pkg.sv
// Shared types for the VGA PLL controller: FSM states and PLLVR presets.
// Preset codes are already in the PLLVR encoded form (64-div, ODSEL map).
package vga_pll_pkg;

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      WAIT_LOCK,
      STABLE,
      RUN,
      ERROR
   } state_t;

   typedef struct packed {
      logic [5:0] idsel;
      logic [5:0] fbdsel;
      logic [5:0] odsel;
   } preset_t;

   // 0: 64.8 MHz, 1: 25.2 MHz, 2: 40 MHz, 3: 74.25 MHz (27 MHz ref)
   localparam preset_t [3:0] PRESET_TBL = {
      preset_t'{idsel: 6'd60, fbdsel: 6'd53, odsel: 6'd60},
      preset_t'{idsel: 6'd37, fbdsel: 6'd24, odsel: 6'd56},
      preset_t'{idsel: 6'd34, fbdsel: 6'd36, odsel: 6'd48},
      preset_t'{idsel: 6'd59, fbdsel: 6'd52, odsel: 6'd60}
   };

   function automatic preset_t preset_of(input logic [1:0] mode);
      return PRESET_TBL[mode];
   endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for the PLL lock flag plus a saturating
// counter of consecutive synchronized lock cycles.
module pll_lock_sync #(
   parameter int STABLE_CYCLES = 1024
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             pll_lock,
   input  logic                             clr,
   output logic                             lock,
   output logic [$clog2(STABLE_CYCLES):0]   stable_cnt
);

   localparam int SW = $clog2(STABLE_CYCLES) + 1;

   logic s1;
   logic s2;

   assign lock = s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1         <= 1'b0;
         s2         <= 1'b0;
         stable_cnt <= '0;
      end else begin
         s1 <= pll_lock;
         s2 <= s1;
         if (clr || !s2)
            stable_cnt <= '0;
         else if (stable_cnt != SW'(STABLE_CYCLES))
            stable_cnt <= stable_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/vga_pll_ctrl.sv
// PLLVR bring-up sequencer: applies a preset, pulses PLL reset, waits
// for a stable lock with retries, and gates the pixel-domain reset.
module vga_pll_ctrl #(
   parameter int RESET_CYCLES  = 16,
   parameter int STABLE_CYCLES = 1024,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int MAX_RETRY     = 3
) (
   input  logic       clkin,
   input  logic       rst,
   input  logic       cfg_req,
   input  logic [1:0] cfg_mode,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic [5:0] pll_idsel,
   output logic [5:0] pll_fbdsel,
   output logic [5:0] pll_odsel,
   output logic       video_rst,
   output logic       cfg_busy,
   output logic       cfg_done,
   output logic       cfg_err
);

   import vga_pll_pkg::*;

   localparam int RW = $clog2(RESET_CYCLES) + 1;
   localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
   localparam int MW = $clog2(MAX_RETRY) + 1;
   localparam int SW = $clog2(STABLE_CYCLES) + 1;

   state_t          state;
   logic [1:0]      mode;
   preset_t         sel;
   logic [RW-1:0]   rst_cnt;
   logic [TW-1:0]   to_cnt;
   logic [MW-1:0]   retry;
   logic            lock;
   logic [SW-1:0]   stable_cnt;
   logic            accept;

   assign pll_idsel  = sel.idsel;
   assign pll_fbdsel = sel.fbdsel;
   assign pll_odsel  = sel.odsel;

   assign accept = cfg_req &&
                   (state == IDLE || state == RUN || state == ERROR);

   pll_lock_sync #(
      .STABLE_CYCLES(STABLE_CYCLES)
   ) u_sync (
      .clk       (clkin),
      .rst       (rst),
      .pll_lock  (pll_lock),
      .clr       (state != STABLE),
      .lock      (lock),
      .stable_cnt(stable_cnt)
   );

   always_ff @(posedge clkin) begin
      if (rst) begin
         state     <= APPLY;
         mode      <= 2'd0;
         sel       <= preset_of(2'd0);
         rst_cnt   <= '0;
         to_cnt    <= '0;
         retry     <= '0;
         pll_reset <= 1'b1;
         video_rst <= 1'b1;
         cfg_busy  <= 1'b1;
         cfg_done  <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         cfg_done <= 1'b0;
         // a new request outranks lock loss in RUN
         if (accept) begin
            state     <= APPLY;
            mode      <= cfg_mode;
            sel       <= preset_of(cfg_mode);
            rst_cnt   <= '0;
            to_cnt    <= '0;
            retry     <= '0;
            cfg_err   <= 1'b0;
            pll_reset <= 1'b1;
            video_rst <= 1'b1;
            cfg_busy  <= 1'b1;
         end else begin
            unique case (state)
               IDLE: begin
                  pll_reset <= 1'b0;
                  video_rst <= 1'b1;
                  cfg_busy  <= 1'b0;
               end
               APPLY: begin
                  if (rst_cnt == RW'(RESET_CYCLES - 1)) begin
                     state     <= WAIT_LOCK;
                     pll_reset <= 1'b0;
                     to_cnt    <= '0;
                  end else if (rst_cnt != RW'(RESET_CYCLES)) begin
                     rst_cnt <= rst_cnt + 1'b1;
                  end
               end
               WAIT_LOCK: begin
                  if (lock) begin
                     state <= STABLE;
                  end else if (to_cnt == TW'(LOCK_TIMEOUT - 1)) begin
                     if (retry < MW'(MAX_RETRY)) begin
                        state     <= APPLY;
                        retry     <= retry + 1'b1;
                        sel       <= preset_of(mode);
                        rst_cnt   <= '0;
                        pll_reset <= 1'b1;
                     end else begin
                        state     <= ERROR;
                        cfg_err   <= 1'b1;
                        pll_reset <= 1'b1;
                        cfg_busy  <= 1'b0;
                     end
                  end else begin
                     to_cnt <= to_cnt + 1'b1;
                  end
               end
               STABLE: begin
                  if (!lock) begin
                     state  <= WAIT_LOCK;
                     to_cnt <= '0;
                  end else if (stable_cnt == SW'(STABLE_CYCLES - 1)) begin
                     state     <= RUN;
                     video_rst <= 1'b0;
                     cfg_busy  <= 1'b0;
                     cfg_done  <= 1'b1;
                  end
               end
               RUN: begin
                  // relock without touching the PLL reset
                  if (!lock) begin
                     state     <= WAIT_LOCK;
                     video_rst <= 1'b1;
                     cfg_busy  <= 1'b1;
                     to_cnt    <= '0;
                     retry     <= '0;
                  end
               end
               ERROR: begin
                  cfg_err   <= 1'b1;
                  pll_reset <= 1'b1;
                  video_rst <= 1'b1;
                  cfg_busy  <= 1'b0;
               end
               default: begin
                  state     <= IDLE;
                  pll_reset <= 1'b0;
                  video_rst <= 1'b1;
                  cfg_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
